fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream.sv | 106 ++++++++++
 tb/tb_fifo_rd_stream.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-side consumer of the async FIFO: pops FWFT words into a 2-entry skid buffer and
// presents them as a registered valid/ready stream with packet framing and a beat count.
//
// state | meaning
// EMPTY | no word buffered, m_valid low
// ONE   | head holds a word, skid free
// TWO   | head and skid both hold words, popping stalls
module fifo_rd_stream #(
    parameter int WIDTH    = 32,
    parameter int PKTLEN   = 16,
    parameter int CNTWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                rempty,
    input  logic [WIDTH-1:0]    rdata,
    output logic                rpop,
    output logic [WIDTH-1:0]    m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [CNTWIDTH-1:0] word_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam logic [15:0] BEAT_LAST = 16'(PKTLEN - 1);

    occ_t             state, state_nx;
    logic [WIDTH-1:0] head, skid;
    logic [15:0]      beat;
    logic             pop, take;
    logic             load_head, load_skid, shift_skid;

    // Gating with rst keeps the FIFO untouched while the buffer is being discarded.
    assign pop     = enable & ~rempty & (state != TWO) & ~rst;
    assign rpop    = pop;
    assign m_valid = (state != EMPTY);
    assign take    = m_valid & m_ready;
    assign m_data  = head;
    assign m_last  = m_valid & (beat == BEAT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load_head  = 1'b0;
        load_skid  = 1'b0;
        shift_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (pop) begin
                    state_nx  = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (pop && !take) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (take && !pop) begin
                    state_nx = EMPTY;
                end else if (take && pop) begin
                    load_head = 1'b1;
                end
            end
            TWO: begin
                if (take) begin
                    state_nx   = ONE;
                    shift_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head)       head <= rdata;
            else if (shift_skid) head <= skid;
            if (load_skid)       skid <= rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat     <= '0;
            word_cnt <= '0;
        end else if (take) begin
            beat     <= (beat == BEAT_LAST) ? 16'd0 : beat + 16'd1;
            word_cnt <= word_cnt + CNTWIDTH'(1);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream: a queue-based FIFO and stream reference model
// predict rpop, data order, framing and word count every cycle.
module tb_fifo_rd_stream;

    localparam int WIDTH    = 32;
    localparam int PKTLEN   = 4;
    localparam int CNTWIDTH = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic                rempty;
    logic [WIDTH-1:0]    rdata;
    logic                rpop;
    logic [WIDTH-1:0]    m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;
    logic [CNTWIDTH-1:0] word_cnt;

    fifo_rd_stream #(.WIDTH(WIDTH), .PKTLEN(PKTLEN), .CNTWIDTH(CNTWIDTH)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rempty(rempty), .rdata(rdata),
        .rpop(rpop), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] fq[$];      // external FIFO contents
    logic [WIDTH-1:0] ob[$];      // words the block should be holding
    logic [WIDTH-1:0] pushed[$];  // every word ever written to the FIFO, in order
    int rx_idx = 0;
    int beats = 0;
    int wcnt = 0;
    int rpop_pulses = 0;
    int nlast = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        rempty = (fq.size() == 0);
        rdata  = (fq.size() != 0) ? fq[0] : 32'hdead_beef;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fq.push_back(w);
        pushed.push_back(w);
    endtask

    task automatic check_outputs();
        chk("m_valid", m_valid, ob.size() > 0);
        if (ob.size() > 0) chk("m_data", m_data, ob[0]);
        chk("m_last", m_last, (ob.size() > 0) && (beats % PKTLEN == PKTLEN - 1));
        chk("word_cnt", word_cnt, wcnt);
    endtask

    // Called at a negative edge; advances one clock and checks the result.
    task automatic cycle(input bit en, input bit rdy, input int npush);
        bit exp_pop, take, stalled;
        logic [WIDTH-1:0] pre_data;
        logic pre_last;
        for (int i = 0; i < npush; i++) push_word($urandom);
        enable  = en;
        m_ready = rdy;
        drive_fifo();
        #1;
        exp_pop = en && (fq.size() > 0) && (ob.size() < 2);
        chk("rpop", rpop, exp_pop);
        chk("rpop_while_empty", rpop & rempty, 1'b0);
        if (rpop) rpop_pulses++;
        take     = (ob.size() > 0) && rdy;
        stalled  = m_valid && !rdy;
        pre_data = m_data;
        pre_last = m_last;
        if (take) begin
            chk("order", m_data, pushed[rx_idx]);
            if (m_last) nlast++;
        end
        @(posedge clk);
        if (take) begin
            void'(ob.pop_front());
            rx_idx++;
            beats++;
            wcnt = (wcnt + 1) % (1 << CNTWIDTH);
        end
        if (exp_pop) ob.push_back(fq.pop_front());
        @(negedge clk);
        check_outputs();
        if (stalled) begin
            chk("hold_data", m_data, pre_data);
            chk("hold_last", m_last, pre_last);
        end
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    task automatic do_reset();
        enable = 1'b1;
        drive_fifo();
        #2 rst = 1'b1;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_word_cnt", word_cnt, '0);
        chk("rst_rpop", rpop, 1'b0);
        rx_idx += ob.size();
        ob.delete();
        beats = 0;
        wcnt  = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_valid", m_valid, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        int target;
        logic [WIDTH-1:0] first;
        rst     = 1'b1;
        enable  = 1'b0;
        m_ready = 1'b0;
        drive_fifo();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Three words, first beat one clock after rempty falls
        cycle(1, 1, 0);
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        repeat (5) cycle(1, 1, 0);
        chk("t1_word_cnt", word_cnt, 3);

        // Back-pressure: only two pops until ready rises
        for (int i = 0; i < 8; i++) push_word($urandom);
        first = fq[0];
        rpop_pulses = 0;
        repeat (5) cycle(1, 0, 0);
        chk("t2_pulses", rpop_pulses, 2);
        chk("t2_head", m_data, first);
        repeat (10) cycle(1, 1, 0);
        chk("t2_word_cnt", word_cnt, 11);

        // Reset while both entries are full; next word out is the FIFO head
        for (int i = 0; i < 4; i++) push_word($urandom);
        repeat (3) cycle(1, 0, 0);
        do_reset();
        first = fq[0];
        cycle(1, 0, 0);
        chk("t6_next_head", m_data, first);
        repeat (6) cycle(1, 1, 0);

        // Framing over ten words from a fresh reset
        do_reset();
        repeat (3) cycle(1, 1, 0);
        nlast = 0;
        for (int i = 0; i < 10; i++) push_word($urandom);
        repeat (14) cycle(1, 1, 0);
        chk("t3_lasts", nlast, 2);
        chk("t3_word_cnt", word_cnt, 10 + 0);

        // Pause with two words buffered, then resume
        for (int i = 0; i < 9; i++) push_word($urandom);
        repeat (4) cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        chk("t5_rpop_off", rpop, 1'b0);
        repeat (3) cycle(0, 1, 0);
        repeat (8) cycle(1, 1, 0);

        // Random traffic, 1000 words
        target = rx_idx + 1000;
        for (int c = 0; c < 8000 && rx_idx < target; c++)
            cycle(($urandom % 8) != 0, $urandom % 2, $urandom % 2);
        chk("t4_received", rx_idx >= target, 1'b1);
        for (int c = 0; c < 200 && (fq.size() > 0 || ob.size() > 0); c++)
            cycle(1, 1, 0);
        chk("t4_drained", (fq.size() == 0) && (ob.size() == 0), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
